systolic_feeder: RTL and testbench

- Transmit side of the MAC array data interface.
- Accepts one operand tile over a valid/ready stream: K beats, each carrying one column of A and one row of B.
- Buffers the tile, then drives the array's row and column inputs with diagonal skew and zero padding.
- Generates the accumulator clear and enable controls, and pulses result_valid_o when the array's result matrix is final.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/feeder_skew_mux.sv | 29 ++
 rtl/systolic_feeder.sv | 115 +++++++++++
 tb/tb_systolic_feeder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared systolic-array types and constants, plus the tile feeder state
// encoding and its feed-phase length helper.
package systolic_pkg;

  localparam int systolic_size_c = 4;

  typedef logic signed [7:0]  t_mac_data;
  typedef logic signed [31:0] t_mac_mul_data;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } t_feeder_state_e;

  // The farthest PE (SIZE-1, SIZE-1) sees its last product 2*(SIZE-1) cycles late
  function automatic int feed_cycles_f(input int size, input int k);
    return k + 2 * size - 2;
  endfunction

endpackage

// File: rtl/feeder_skew_mux.sv
// Selects, for every lane l, element t-l of that lane's buffer, or zero when
// t-l falls outside 0..K_DEPTH-1 or the feeder is not in its feed phase.
module feeder_skew_mux
  import systolic_pkg::*;
#(
  parameter int SIZE    = systolic_size_c,
  parameter int K_DEPTH = systolic_size_c,
  parameter int T_W     = 4
) (
  input  logic [T_W-1:0]                      t,
  input  logic                                active,
  input  t_mac_data [SIZE-1:0][K_DEPTH-1:0]   lane_buf,
  output t_mac_data [SIZE-1:0]                lanes
);

  localparam int IDX_W  = T_W + 1;
  localparam int KIDX_W = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;

  for (genvar l = 0; l < SIZE; l++) begin : g_lane
    logic signed [IDX_W-1:0] idx_s;
    logic                    in_range_s;

    // Widened signed difference so early cycles (t < l) read as negative, not wrapped
    assign idx_s      = $signed({1'b0, t}) - IDX_W'(l);
    assign in_range_s = !idx_s[IDX_W-1] && (idx_s < IDX_W'(K_DEPTH));
    assign lanes[l]   = (active && in_range_s) ? lane_buf[l][idx_s[KIDX_W-1:0]] : 8'sd0;
  end

endmodule

// File: rtl/systolic_feeder.sv
// Transmit side of the MAC array data interface: buffers one K-beat operand
// tile, then replays it into the array with diagonal skew and zero padding.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int SIZE    = systolic_size_c,
  parameter int K_DEPTH = systolic_size_c
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  t_mac_data [SIZE-1:0]   in_a_col_i,
  input  t_mac_data [SIZE-1:0]   in_b_row_i,
  output t_mac_data [SIZE-1:0]   a_rows_o,
  output t_mac_data [SIZE-1:0]   b_columns_o,
  output logic                   mac_clear_o,
  output logic                   mac_en_o,
  output logic                   result_valid_o,
  output logic                   busy_o
);

  localparam int FEED_CYCLES = feed_cycles_f(SIZE, K_DEPTH);
  localparam int T_W         = $clog2(FEED_CYCLES + 1);
  localparam int BEAT_W      = $clog2(K_DEPTH + 1);
  localparam int KIDX_W      = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;

  t_feeder_state_e  state_r;
  logic [T_W-1:0]   t_r;
  logic [BEAT_W-1:0] beat_r;
  logic             feed_s;
  logic             accept_s;

  // a_buf_r[i][k] = A[i][k]; bt_buf_r[j][k] = B[k][j], stored transposed so both muxes index alike
  t_mac_data [SIZE-1:0][K_DEPTH-1:0] a_buf_r;
  t_mac_data [SIZE-1:0][K_DEPTH-1:0] bt_buf_r;

  assign feed_s   = (state_r == FEED);
  assign accept_s = (state_r == LOAD) && in_valid_i;

  // Tile sequencing: LOAD -> CLEAR -> FEED (FEED_CYCLES) -> DONE -> LOAD
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r <= LOAD;
      t_r     <= '0;
      beat_r  <= '0;
    end else begin
      case (state_r)
        LOAD: begin
          if (in_valid_i) begin
            if (beat_r == BEAT_W'(K_DEPTH - 1)) begin
              beat_r  <= '0;
              state_r <= CLEAR;
            end else begin
              beat_r <= beat_r + BEAT_W'(1);
            end
          end
        end
        CLEAR: begin
          t_r     <= '0;
          state_r <= FEED;
        end
        FEED: begin
          if (t_r == T_W'(FEED_CYCLES - 1)) begin
            t_r     <= '0;
            state_r <= DONE;
          end else begin
            t_r <= t_r + T_W'(1);
          end
        end
        DONE:    state_r <= LOAD;
        default: state_r <= LOAD;
      endcase
    end
  end

  // Operand capture; contents are only meaningful once a full tile has loaded
  always_ff @(posedge clock_i) begin
    if (accept_s) begin
      for (int l = 0; l < SIZE; l++) begin
        a_buf_r[l][beat_r[KIDX_W-1:0]]  <= in_a_col_i[l];
        bt_buf_r[l][beat_r[KIDX_W-1:0]] <= in_b_row_i[l];
      end
    end
  end

  feeder_skew_mux #(
    .SIZE    (SIZE),
    .K_DEPTH (K_DEPTH),
    .T_W     (T_W)
  ) u_a_mux (
    .t        (t_r),
    .active   (feed_s),
    .lane_buf (a_buf_r),
    .lanes    (a_rows_o)
  );

  feeder_skew_mux #(
    .SIZE    (SIZE),
    .K_DEPTH (K_DEPTH),
    .T_W     (T_W)
  ) u_b_mux (
    .t        (t_r),
    .active   (feed_s),
    .lane_buf (bt_buf_r),
    .lanes    (b_columns_o)
  );

  assign in_ready_o     = (state_r == LOAD);
  assign busy_o         = (state_r != LOAD);
  assign mac_clear_o    = (state_r == CLEAR);
  assign mac_en_o       = feed_s;
  assign result_valid_o = (state_r == DONE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: drives operand tiles, checks skewed feed vectors
// and control timing, and multiplies through a behavioural MAC array.
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int N = 4;
  localparam int K = 4;
  localparam int F = K + 2 * N - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready, clr, en, rv, busy;
  t_mac_data [N-1:0] a_col, b_row, a_rows, b_cols;

  int total = 0;
  int bad = 0;
  int ma[N][K];
  int mb[K][N];
  int exp_a_q[$];
  int exp_b_q[$];
  int exp_c_q[$];
  int acc[N][N];
  int pa[N][N];
  int pb[N][N];

  always #5 clk = ~clk;

  systolic_feeder #(.SIZE(N), .K_DEPTH(K)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_a_col_i     (a_col),
    .in_b_row_i     (b_row),
    .a_rows_o       (a_rows),
    .b_columns_o    (b_cols),
    .mac_clear_o    (clr),
    .mac_en_o       (en),
    .result_valid_o (rv),
    .busy_o         (busy)
  );

  // Behavioural output-stationary MAC array: a moves right, b moves down
  function automatic int a_in_f(int i, int j);
    return (j == 0) ? int'(a_rows[i]) : pa[i][(j == 0) ? 0 : j - 1];
  endfunction

  function automatic int b_in_f(int i, int j);
    return (i == 0) ? int'(b_cols[j]) : pb[(i == 0) ? 0 : i - 1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst || clr) begin
          acc[i][j] <= 0;
          pa[i][j]  <= 0;
          pb[i][j]  <= 0;
        end else begin
          pa[i][j] <= a_in_f(i, j);
          pb[i][j] <= b_in_f(i, j);
          if (en) acc[i][j] <= acc[i][j] + a_in_f(i, j) * b_in_f(i, j);
        end
      end
    end
  end

  task automatic push_expect();
    int c;
    for (int t = 0; t < F; t++) begin
      for (int l = 0; l < N; l++) begin
        if (t - l >= 0 && t - l < K) begin
          exp_a_q.push_back(ma[l][t - l]);
          exp_b_q.push_back(mb[t - l][l]);
        end else begin
          exp_a_q.push_back(0);
          exp_b_q.push_back(0);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        c = 0;
        for (int k = 0; k < K; k++) c += ma[i][k] * mb[k][j];
        exp_c_q.push_back(c);
      end
    end
  endtask

  // mode 0: 16i+k / 16k+j, 1: identity A, 2: all -128, 3: random
  task automatic set_tile(input int mode);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < K; k++) begin
        case (mode)
          0: begin ma[i][k] = 16 * i + k; mb[k][i] = 16 * k + i; end
          1: begin ma[i][k] = (i == k) ? 1 : 0; mb[k][i] = k * 4 + i; end
          2: begin ma[i][k] = -128; mb[k][i] = -128; end
          default: begin
            ma[i][k] = int'($urandom_range(0, 255)) - 128;
            mb[k][i] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
      end
    end
    push_expect();
  endtask

  // Starts at a negedge; leaves us at the negedge of the CLEAR cycle
  task automatic drive_load(input int n, input logic [15:0] pat);
    int k = 0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL load_ready beat=%0d got=%b want=1", k, in_ready);
      end
      in_valid = pat[c];
      for (int l = 0; l < N; l++) begin
        if (pat[c]) begin
          a_col[l] = 8'(ma[l][k]);
          b_row[l] = 8'(mb[k][l]);
        end else begin
          a_col[l] = 8'sh5A;
          b_row[l] = -8'sd77;
        end
      end
      if (pat[c]) k++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Cycle 1 is CLEAR, 2..F+1 FEED, F+2 DONE, then one LOAD cycle is checked
  task automatic finish_tile(input bit noisy, input int abort_cyc);
    logic [4:0] want;
    int e;
    for (int cyc = 1; cyc <= F + 2; cyc++) begin
      if (cyc > 1) @(negedge clk);
      in_valid = noisy;
      if (noisy) begin
        for (int l = 0; l < N; l++) begin
          a_col[l] = 8'($urandom);
          b_row[l] = 8'($urandom);
        end
      end
      want = (cyc == 1) ? 5'b01100 : (cyc <= F + 1) ? 5'b01010 : 5'b01001;
      total++;
      if ({in_ready, busy, clr, en, rv} !== want) begin
        bad++;
        $display("FAIL ctl cyc=%0d got=%b want=%b", cyc, {in_ready, busy, clr, en, rv}, want);
      end
      if (cyc >= 2 && cyc <= F + 1) begin
        for (int l = 0; l < N; l++) begin
          e = exp_a_q.pop_front();
          total++;
          if (int'(a_rows[l]) !== e) begin
            bad++;
            $display("FAIL a_row t=%0d lane=%0d got=%0d want=%0d", cyc - 2, l, a_rows[l], e);
          end
          e = exp_b_q.pop_front();
          total++;
          if (int'(b_cols[l]) !== e) begin
            bad++;
            $display("FAIL b_col t=%0d lane=%0d got=%0d want=%0d", cyc - 2, l, b_cols[l], e);
          end
        end
      end else begin
        total++;
        if ({a_rows, b_cols} !== '0) begin
          bad++;
          $display("FAIL pad_idle cyc=%0d got=%h want=0", cyc, {a_rows, b_cols});
        end
      end
      if (cyc == F + 2) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            e = exp_c_q.pop_front();
            total++;
            if (acc[i][j] !== e) begin
              bad++;
              $display("FAIL result C[%0d][%0d] got=%0d want=%0d", i, j, acc[i][j], e);
            end
          end
        end
      end
      if (cyc == abort_cyc) begin
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({in_ready, busy, clr, en, rv, a_rows, b_cols} !== {5'b10000, 64'd0}) begin
          bad++;
          $display("FAIL abort_state got=%b/%h want=10000/0", {in_ready, busy, clr, en, rv}, {a_rows, b_cols});
        end
        exp_a_q.delete();
        exp_b_q.delete();
        exp_c_q.delete();
        return;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({in_ready, busy, clr, en, rv} !== 5'b10000) begin
      bad++;
      $display("FAIL ready_after_done got=%b want=10000", {in_ready, busy, clr, en, rv});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_col = '0;
    b_row = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, busy, clr, en, rv, a_rows, b_cols} !== {5'b10000, 64'd0}) begin
      bad++;
      $display("FAIL reset_state got=%b/%h want=10000/0", {in_ready, busy, clr, en, rv}, {a_rows, b_cols});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_skew();
    set_tile(0);
    drive_load(4, 16'h000F);
    finish_tile(1'b0, 0);
  endtask

  task automatic test_identity();
    set_tile(1);
    drive_load(4, 16'h000F);
    finish_tile(1'b0, 0);
  endtask

  task automatic test_signed_extremes();
    set_tile(2);
    drive_load(4, 16'h000F);
    finish_tile(1'b0, 0);
  endtask

  task automatic test_gaps_and_ignored();
    set_tile(0);
    drive_load(7, 16'h0059);
    finish_tile(1'b1, 0);
  endtask

  task automatic test_abort();
    set_tile(3);
    drive_load(4, 16'h000F);
    finish_tile(1'b0, 7);
    set_tile(3);
    drive_load(4, 16'h000F);
    finish_tile(1'b0, 0);
  endtask

  task automatic test_back_to_back();
    set_tile(3);
    drive_load(4, 16'h000F);
    finish_tile(1'b0, 0);
    set_tile(2);
    drive_load(4, 16'h000F);
    finish_tile(1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_skew();
    test_identity();
    test_signed_extremes();
    test_gaps_and_ignored();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
